// File: rtl/operand_loader_if.sv
// Byte-stream in / assembled-operand out bus of the operand loader.
// master = producer/consumer side, slave = the loader itself.
interface operand_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [4:0]  out_a;
  logic [15:0] out_b;
  logic [15:0] out_c;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_a, out_b, out_c, out_valid, frame_err, frame_cnt
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_a, out_b, out_c, out_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/operand_loader.sv
// Assembles 5-byte little-endian frames (A, B lo/hi, C lo/hi) into operands
// and holds each frame until the downstream consumer accepts it.
module operand_loader #(
  parameter bit CHECK_PAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_loader_if.slave   bus
);

  localparam int unsigned A_W   = 5;
  localparam int unsigned OP_W  = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {LD_A, LD_B0, LD_B1, LD_C0, LD_C1, HOLD} state_e;

  state_e            state_q, state_d;
  logic [A_W-1:0]    out_a_q, out_a_d;
  logic [OP_W-1:0]   out_b_q, out_b_d;
  logic [OP_W-1:0]   out_c_q, out_c_d;
  logic              pad_q, pad_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              xfer;

  // Next-state and datapath; flush only applies while loading.
  always_comb begin
    state_d     = state_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    pad_d       = pad_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;
    xfer        = bus.in_valid && in_ready_q;

    if ((state_q != HOLD) && bus.flush) begin
      state_d = LD_A;
      pad_d   = 1'b0;
    end else begin
      unique case (state_q)
        LD_A: if (xfer) begin
          out_a_d = bus.in_data[4:0];
          pad_d   = CHECK_PAD && (bus.in_data[7:5] != 3'b000);
          state_d = LD_B0;
        end
        LD_B0: if (xfer) begin
          out_b_d[7:0] = bus.in_data;
          state_d      = LD_B1;
        end
        LD_B1: if (xfer) begin
          out_b_d[15:8] = bus.in_data;
          state_d       = LD_C0;
        end
        LD_C0: if (xfer) begin
          out_c_d[7:0] = bus.in_data;
          state_d      = LD_C1;
        end
        LD_C1: if (xfer) begin
          out_c_d[15:8] = bus.in_data;
          state_d       = HOLD;
        end
        HOLD: if (bus.out_ready) begin
          state_d     = LD_A;
          frame_cnt_d = frame_cnt_q + 8'd1;
          frame_err_d = pad_q;
          pad_d       = 1'b0;
        end
        default: state_d = LD_A;
      endcase
    end

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LD_A;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      pad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      pad_q       <= pad_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // in_ready is gated by rst_n so it reads low throughout reset cycles.
  assign bus.in_ready  = in_ready_q && rst_n;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: constant vector table, directed
// corner sequences and randomized traffic against a frame-level model.
module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  operand_loader_if bus1 ();
  operand_loader_if bus0 ();

  assign bus1.in_data   = in_data;
  assign bus1.in_valid  = in_valid;
  assign bus1.flush     = flush;
  assign bus1.out_ready = out_ready;
  assign bus0.in_data   = in_data;
  assign bus0.in_valid  = in_valid;
  assign bus0.flush     = flush;
  assign bus0.out_ready = out_ready;

  operand_loader #(.CHECK_PAD(1'b1)) dut_pad   (.clk(clk), .rst_n(rst_n), .bus(bus1));
  operand_loader #(.CHECK_PAD(1'b0)) dut_nopad (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference model: bytes collected so far, held flag, counters.
  int m_bytes[$];
  bit m_hold;
  bit m_pad;
  bit m_err;
  int m_a, m_b, m_c, m_cnt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit v, int d, bit fl, bit ordy, bit rst);
    m_err = 1'b0;
    if (!rst) begin
      m_bytes.delete();
      m_hold = 1'b0; m_pad = 1'b0; m_cnt = 0;
      m_a = 0; m_b = 0; m_c = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        m_err  = m_pad;
        m_pad  = 1'b0;
        m_cnt  = (m_cnt + 1) % 256;
        m_bytes.delete();
      end
    end else if (fl) begin
      m_bytes.delete();
      m_pad = 1'b0;
    end else if (v) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 1) begin
        m_a   = d % 32;
        m_pad = (d >= 32);
      end
      if (m_bytes.size() == 5) begin
        m_b    = m_bytes[1] + 256 * m_bytes[2];
        m_c    = m_bytes[3] + 256 * m_bytes[4];
        m_hold = 1'b1;
      end
    end
  endfunction

  function automatic void check_outputs();
    chk("in_ready",     32'(bus1.in_ready),  32'(rst_n && !m_hold));
    chk("out_valid",    32'(bus1.out_valid), 32'(m_hold));
    chk("frame_err",    32'(bus1.frame_err), 32'(m_err));
    chk("frame_cnt",    32'(bus1.frame_cnt), 32'(m_cnt));
    chk("nopad_valid",  32'(bus0.out_valid), 32'(m_hold));
    chk("nopad_err",    32'(bus0.frame_err), 32'd0);
    chk("nopad_cnt",    32'(bus0.frame_cnt), 32'(m_cnt));
    if (m_hold) begin
      chk("out_a", 32'(bus1.out_a), 32'(m_a));
      chk("out_b", 32'(bus1.out_b), 32'(m_b));
      chk("out_c", 32'(bus1.out_c), 32'(m_c));
      chk("nopad_out_a", 32'(bus0.out_a), 32'(m_a));
    end
  endfunction

  // One clock: drive inputs, advance the model, check #1 after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic fl,
                       input logic ordy, input logic rst);
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    rst_n     = rst;
    model_step(v, int'(d), fl, ordy, rst);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic ordy);
    cycle(1'b1, b0, 1'b0, ordy, 1'b1);
    cycle(1'b1, b1, 1'b0, ordy, 1'b1);
    cycle(1'b1, b2, 1'b0, ordy, 1'b1);
    cycle(1'b1, b3, 1'b0, ordy, 1'b1);
    cycle(1'b1, b4, 1'b0, ordy, 1'b1);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fl;
    logic        ordy;
    logic        rst;
    logic        ev;
    logic [4:0]  ea;
    logic [15:0] eb;
    logic [15:0] ec;
    logic [7:0]  ecnt;
    logic        eerr;
  } vec_t;

  function automatic vec_t mkv(logic v, logic [7:0] d, logic ordy, logic rst, logic ev,
                               logic [4:0] ea, logic [15:0] eb, logic [15:0] ec,
                               logic [7:0] ecnt, logic eerr);
    vec_t r;
    r.v = v; r.d = d; r.fl = 1'b0; r.ordy = ordy; r.rst = rst;
    r.ev = ev; r.ea = ea; r.eb = eb; r.ec = ec; r.ecnt = ecnt; r.eerr = eerr;
    return r;
  endfunction

  vec_t tbl[15];

  initial begin
    in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    m_hold = 1'b0; m_pad = 1'b0; m_err = 1'b0; m_a = 0; m_b = 0; m_c = 0; m_cnt = 0;

    // Basic frame with continuous valid, then a padded frame held one extra cycle.
    tbl[0]  = mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd0, 1'b0);
    tbl[1]  = mkv(1'b1, 8'h15, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd0, 1'b0);
    tbl[2]  = mkv(1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd0, 1'b0);
    tbl[3]  = mkv(1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd0, 1'b0);
    tbl[4]  = mkv(1'b1, 8'hCD, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd0, 1'b0);
    tbl[5]  = mkv(1'b1, 8'hAB, 1'b1, 1'b1, 1'b1, 5'h15, 16'h1234, 16'hABCD, 8'd0, 1'b0);
    tbl[6]  = mkv(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[7]  = mkv(1'b1, 8'hF5, 1'b0, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[8]  = mkv(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[9]  = mkv(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[10] = mkv(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[11] = mkv(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 5'h15, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[12] = mkv(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'h15, 16'h0000, 16'h0000, 8'd1, 1'b0);
    tbl[13] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd2, 1'b1);
    tbl[14] = mkv(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00, 16'h0000, 16'h0000, 8'd2, 1'b0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].ordy, tbl[i].rst);
      chk("tbl_valid", 32'(bus1.out_valid), 32'(tbl[i].ev));
      chk("tbl_cnt",   32'(bus1.frame_cnt), 32'(tbl[i].ecnt));
      chk("tbl_err",   32'(bus1.frame_err), 32'(tbl[i].eerr));
      if (tbl[i].ev) begin
        chk("tbl_a", 32'(bus1.out_a), 32'(tbl[i].ea));
        chk("tbl_b", 32'(bus1.out_b), 32'(tbl[i].eb));
        chk("tbl_c", 32'(bus1.out_c), 32'(tbl[i].ec));
      end
    end

    // Back-pressure: frame held for 10 cycles while bytes and flush are offered.
    send_frame(8'h1F, 8'h22, 8'h11, 8'h44, 8'h33, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom), 1'(i % 2), 1'b0, 1'b1);
      chk("hold_a",   32'(bus1.out_a), 32'h1F);
      chk("hold_b",   32'(bus1.out_b), 32'h1122);
      chk("hold_c",   32'(bus1.out_c), 32'h3344);
      chk("hold_rdy", 32'(bus1.in_ready), 32'd0);
      chk("hold_cnt", 32'(bus1.frame_cnt), 32'd2);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("hold_acc_cnt", 32'(bus1.frame_cnt), 32'd3);

    // Flush after 3 bytes, same-cycle byte ignored, then a clean frame.
    cycle(1'b1, 8'h09, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h08, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h07, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    send_frame(8'h01, 8'h02, 8'h00, 8'h03, 8'h00, 1'b0);
    chk("flush_a", 32'(bus1.out_a), 32'h01);
    chk("flush_b", 32'(bus1.out_b), 32'h0002);
    chk("flush_c", 32'(bus1.out_c), 32'h0003);
    chk("flush_cnt_hold", 32'(bus1.frame_cnt), 32'd3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("flush_cnt", 32'(bus1.frame_cnt), 32'd4);

    // Reset in LD_C0 then a fresh frame.
    cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h04, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h06, 1'b1, 1'b1, 1'b0);
    chk("rst_c0_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_c0_cnt",   32'(bus1.frame_cnt), 32'd0);
    chk("rst_c0_a",     32'(bus1.out_a), 32'd0);
    chk("rst_c0_b",     32'(bus1.out_b), 32'd0);
    chk("rst_c0_c",     32'(bus1.out_c), 32'd0);
    chk("rst_c0_rdy",   32'(bus1.in_ready), 32'd0);
    send_frame(8'h0A, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 1'b0);
    chk("rst_c0_fresh_b", 32'(bus1.out_b), 32'h9ABC);
    chk("rst_c0_fresh_c", 32'(bus1.out_c), 32'hDEF0);

    // Reset while holding, with out_ready also high.
    cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("rst_hold_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_hold_cnt",   32'(bus1.frame_cnt), 32'd0);
    chk("rst_hold_err",   32'(bus1.frame_err), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_hold_rdy",   32'(bus1.in_ready), 32'd1);

    // 256 deliveries wrap frame_cnt to 0; the 257th gives 1.
    for (int f = 0; f < 256; f++) begin
      send_frame(8'(f), 8'(f + 1), 8'(f + 2), 8'(f + 3), 8'(f + 4), 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    end
    chk("wrap_256", 32'(bus1.frame_cnt), 32'd0);
    send_frame(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("wrap_257", 32'(bus1.frame_cnt), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 99) < 70), 8'($urandom), 1'($urandom_range(0, 99) < 5),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 199) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CHECK_PAD, default 1; when 1, nonzero bits [7:5] of the A byte raise frame_err.
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data  input  8  upstream byte.
REQ-005 The block SHALL have port in_valid  input  1  in_data valid.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-007 The block SHALL have port flush  input  1  abandon the partial frame.
REQ-008 The block SHALL have port out_a  output  5  assembled 5-bit operand A.
REQ-009 The block SHALL have port out_b  output  16  assembled operand B.
REQ-010 The block SHALL have port out_c  output  16  assembled operand C.
REQ-011 The block SHALL have port out_valid  output  1  out_a/out_b/out_c hold a complete frame.
REQ-012 The block SHALL have port out_ready  input  1  downstream operand consumer accepts the frame.
REQ-013 The block SHALL have port frame_err  output  1  one-cycle pulse, pad violation on the completed frame.
REQ-014 The block SHALL have port frame_cnt  output  8  count of frames delivered, wraps 255->0.

Function
REQ-015 The block SHALL treat a byte as transferred only in a cycle with in_valid=1 and in_ready=1.
REQ-016 The block SHALL consume 5-byte frames in order: A, B low, B high, C low, C high (little-endian).
REQ-017 The block SHALL use FSM states LD_A, LD_B0, LD_B1, LD_C0, LD_C1, HOLD; each LD state advances to the next state on a transfer and holds otherwise.
REQ-018 The block SHALL capture in_data[4:0] into out_a in LD_A and record a pad violation when CHECK_PAD=1 and in_data[7:5]!=0.
REQ-019 The block SHALL drive in_ready=1 in every LD state and in_ready=0 in HOLD.
REQ-020 The block SHALL move LD_C1 -> HOLD on transfer, with out_valid=1 from the next cycle (latency one cycle after the 5th byte).
REQ-021 The block SHALL drive out_valid=1 only in HOLD and keep out_a/out_b/out_c stable while out_valid=1 and out_ready=0.
REQ-022 The block SHALL, in HOLD with out_ready=1, go to LD_A, increment frame_cnt modulo 256, and pulse frame_err if the frame had a pad violation.
REQ-023 The block SHALL update out_a/out_b/out_c during loading; their values are don't-care while out_valid=0.
REQ-024 The block SHALL, on flush=1 in any LD state, go to LD_A next cycle, discard the partial frame and the pad flag, and ignore any same-cycle byte.
REQ-025 The block SHALL ignore flush in HOLD; the held frame is delivered normally.
REQ-026 The block SHALL drop out_valid in the cycle after acceptance; back-to-back frames therefore see at least 5 cycles of out_valid=0.

Reset
REQ-027 The block SHALL, on any clock edge with rst_n=0, enter LD_A, clear the pad flag, and force out_valid=0, frame_err=0, frame_cnt=0, out_a=0, out_b=0, out_c=0.
REQ-028 The block SHALL hold in_ready=0 during reset cycles.
REQ-029 The block SHALL let reset override flush, in_valid, and out_ready, including mid-frame and in HOLD.

Verification
REQ-030 The bench SHALL cover this case: bytes 0x15,0x34,0x12,0xCD,0xAB with continuous valid and out_ready=1 -> out_a=0x15, out_b=0x1234, out_c=0xABCD, out_valid one cycle, frame_cnt=1, frame_err=0.
REQ-031 The bench SHALL cover this case: A byte 0xF5, CHECK_PAD=1 -> out_a=0x15; on acceptance frame_err pulses exactly one cycle. With CHECK_PAD=0, frame_err stays 0.
REQ-032 The bench SHALL cover this case: out_ready=0 for 10 cycles after frame completion -> out_valid stays 1, outputs constant, in_ready=0, frame_cnt unchanged until acceptance.
REQ-033 The bench SHALL cover this case: flush after 3 bytes, then a full frame 0x01,0x02,0x00,0x03,0x00 -> out_a=0x01, out_b=0x0002, out_c=0x0003, frame_cnt increments by 1 only.
REQ-034 The bench SHALL cover this case: 256 frames delivered -> frame_cnt wraps to 0; 257th gives 1.
REQ-035 The bench SHALL cover this case: rst_n=0 for one cycle in LD_C0 or in HOLD -> next cycle out_valid=0, frame_cnt=0, state LD_A; the next 5 bytes form a fresh frame.
